// File: rtl/sap_pkg.sv
// Shared constants for the SAP microsequencer: opcodes, control-word bit
// positions and the stage encoding reported on the stage output.
package sap_pkg;

  // Opcodes (IR[7:4])
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_JC  = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control-word bit positions; bits 11:0 match the legacy datapath
  localparam int CW_ADDER_OUT  = 0;
  localparam int CW_SUB        = 1;
  localparam int CW_B_LOAD     = 2;
  localparam int CW_A_OUT      = 3;
  localparam int CW_A_LOAD     = 4;
  localparam int CW_IR_OUT     = 5;
  localparam int CW_IR_LOAD    = 6;
  localparam int CW_MEM_OUT    = 7;
  localparam int CW_MAR_LOAD   = 8;
  localparam int CW_PC_OUT     = 9;
  localparam int CW_PC_INC     = 10;
  localparam int CW_HLT        = 11;
  localparam int CW_PC_LOAD    = 12;
  localparam int CW_OUT_LOAD   = 13;
  localparam int CW_FLAGS_LOAD = 14;

  // Stage encoding, doubles as the sequencer state encoding
  localparam logic [2:0] ST_WAIT = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_T3   = 3'd3;
  localparam logic [2:0] ST_T4   = 3'd4;
  localparam logic [2:0] ST_T5   = 3'd5;
  localparam logic [2:0] ST_T6   = 3'd6;
  localparam logic [2:0] ST_HALT = 3'd7;

  // One-hot mask for a single control bit
  function automatic logic [15:0] cw_bit(input int idx);
    cw_bit = 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/sap_microcode_rom.sv
// Combinational microcode: (stage, opcode, flags) -> control word plus a
// marker for the final T-state of the current instruction.
module sap_microcode_rom
  import sap_pkg::*;
(
  input  logic [2:0]  stage,
  input  logic [3:0]  opcode,
  input  logic [1:0]  flags,      // {C,Z}
  output logic [15:0] ctrl_word,
  output logic        last_step
);

  // Microcode lookup; unreachable T5/T6 slots end the instruction so a
  // corrupted opcode can never wedge the sequencer.
  always_comb begin
    ctrl_word = 16'h0000;
    last_step = 1'b0;
    case (stage)
      ST_T1: ctrl_word = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_LOAD);
      ST_T2: ctrl_word = cw_bit(CW_PC_INC);
      ST_T3: ctrl_word = cw_bit(CW_MEM_OUT) | cw_bit(CW_IR_LOAD);
      ST_T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB:
            ctrl_word = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_LOAD);
          OP_JMP: begin
            ctrl_word = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
            last_step = 1'b1;
          end
          OP_JC: begin
            if (flags[1]) ctrl_word = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
            last_step = 1'b1;
          end
          OP_JZ: begin
            if (flags[0]) ctrl_word = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
            last_step = 1'b1;
          end
          OP_LDI: begin
            ctrl_word = cw_bit(CW_IR_OUT) | cw_bit(CW_A_LOAD);
            last_step = 1'b1;
          end
          OP_OUT: begin
            ctrl_word = cw_bit(CW_A_OUT) | cw_bit(CW_OUT_LOAD);
            last_step = 1'b1;
          end
          OP_HLT: begin
            ctrl_word = cw_bit(CW_HLT);
            last_step = 1'b1;
          end
          default: last_step = 1'b1;  // undefined opcodes act as NOP
        endcase
      end
      ST_T5: begin
        case (opcode)
          OP_LDA: begin
            ctrl_word = cw_bit(CW_MEM_OUT) | cw_bit(CW_A_LOAD);
            last_step = 1'b1;
          end
          OP_ADD, OP_SUB: ctrl_word = cw_bit(CW_MEM_OUT) | cw_bit(CW_B_LOAD);
          default: last_step = 1'b1;
        endcase
      end
      ST_T6: begin
        last_step = 1'b1;
        case (opcode)
          OP_ADD:
            ctrl_word = cw_bit(CW_ADDER_OUT) | cw_bit(CW_A_LOAD) | cw_bit(CW_FLAGS_LOAD);
          OP_SUB:
            ctrl_word = cw_bit(CW_ADDER_OUT) | cw_bit(CW_SUB) | cw_bit(CW_A_LOAD)
                      | cw_bit(CW_FLAGS_LOAD);
          default: ctrl_word = 16'h0000;
        endcase
      end
      ST_HALT: ctrl_word = cw_bit(CW_HLT);
      default: ctrl_word = 16'h0000;  // ST_WAIT
    endcase
  end

endmodule

// File: rtl/sap_microsequencer.sv
// SAP control unit: T-state sequencer with flags register, run/single-step
// control and halt handling. The control word comes straight from the
// microcode ROM; the state register is visible on the stage output.
module sap_microsequencer
  import sap_pkg::*;
#(
  parameter bit STEP_EN     = 1'b1,
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode,
  input  logic        carry,
  input  logic        zero,
  input  logic        run,
  input  logic        step,
  output logic [15:0] ctrl_word,
  output logic [2:0]  stage,
  output logic [1:0]  flags,
  output logic        halted,
  output logic        instr_done
);

  logic [2:0] state_q, state_d;
  logic [1:0] flags_q, flags_d;
  logic       step_q, step_d;
  logic       run_q, run_d;
  logic       rom_last;
  logic       run_eff, step_rise, run_rise, in_tstate;

  sap_microcode_rom u_rom (
    .stage     (state_q),
    .opcode    (opcode),
    .flags     (flags_q),
    .ctrl_word (ctrl_word),
    .last_step (rom_last)
  );

  // Mode qualifiers: effective run level and one-cycle edge detects
  always_comb begin
    run_eff   = STEP_EN ? run : 1'b1;
    step_rise = STEP_EN && step && !step_q;
    run_rise  = run && !run_q;
    in_tstate = (state_q != ST_WAIT) && (state_q != ST_HALT);
  end

  // Next-state, flag and edge-register logic
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    step_d  = step;
    run_d   = run;

    // Flags load on the edge that ends any state asserting flags_load
    if (ctrl_word[CW_FLAGS_LOAD]) flags_d = {carry, zero};

    case (state_q)
      ST_WAIT: begin
        if (run_eff || step_rise) state_d = ST_T1;
      end
      ST_HALT: begin
        if (!HALT_STICKY && (step_rise || (STEP_EN && run_rise))) state_d = ST_WAIT;
      end
      default: begin
        // Run is sampled only here, at the instruction boundary
        if (rom_last) begin
          if (ctrl_word[CW_HLT]) state_d = ST_HALT;
          else if (run_eff)      state_d = ST_T1;
          else                   state_d = ST_WAIT;
        end else begin
          state_d = state_q + 3'd1;
        end
      end
    endcase
  end

  // State, flags and edge registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_WAIT;
      flags_q <= 2'b00;
      step_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      step_q  <= step_d;
      run_q   <= run_d;
    end
  end

  assign stage      = state_q;
  assign flags      = flags_q;
  assign halted     = (state_q == ST_HALT);
  assign instr_done = in_tstate && rom_last;

endmodule

// File: tb/tb_sap_microsequencer.sv
// Bench for sap_microsequencer: per-instruction expected control-word
// sequences built from the instruction table, checked cycle by cycle.
module tb_sap_microsequencer;

  logic        clk, rst;
  logic [3:0]  opcode;
  logic        carry, zero, run, step;
  logic [15:0] ctrl_word;
  logic [2:0]  stage;
  logic [1:0]  flags;
  logic        halted, instr_done;

  int vectors     = 0;
  int miscompares = 0;

  logic [1:0]  mflags;     // model {C,Z}
  logic [15:0] exp_q[$];   // expected control words for one instruction

  sap_microsequencer dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .carry      (carry),
    .zero       (zero),
    .run        (run),
    .step       (step),
    .ctrl_word  (ctrl_word),
    .stage      (stage),
    .flags      (flags),
    .halted     (halted),
    .instr_done (instr_done)
  );

  // Clock and initial reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference instruction table: fetch words then execute words
  task automatic build_expected(input logic [3:0] op, input logic [1:0] fl);
    exp_q.delete();
    exp_q.push_back(16'h0300);
    exp_q.push_back(16'h0400);
    exp_q.push_back(16'h00C0);
    case (op)
      4'h0: begin exp_q.push_back(16'h0120); exp_q.push_back(16'h0090); end
      4'h1: begin exp_q.push_back(16'h0120); exp_q.push_back(16'h0084); exp_q.push_back(16'h4011); end
      4'h2: begin exp_q.push_back(16'h0120); exp_q.push_back(16'h0084); exp_q.push_back(16'h4013); end
      4'h3: exp_q.push_back(16'h1020);
      4'h4: exp_q.push_back(fl[1] ? 16'h1020 : 16'h0000);
      4'h5: exp_q.push_back(fl[0] ? 16'h1020 : 16'h0000);
      4'h6: exp_q.push_back(16'h0030);
      4'hE: exp_q.push_back(16'h2008);
      4'hF: exp_q.push_back(16'h0800);
      default: exp_q.push_back(16'h0000);
    endcase
  endtask

  // Drive one instruction starting at a negedge where the DUT is in T1.
  // run is set to run_after during the instruction; it returns at the
  // negedge following the final T-state.
  task automatic exec_instr(input logic [3:0] op, input logic c, input logic z,
                            input logic run_after);
    logic [15:0] w;
    logic        last;
    int          k;
    build_expected(op, mflags);
    opcode = op; carry = c; zero = z;
    k = 0;
    while (exp_q.size() > 0) begin
      w    = exp_q.pop_front();
      last = (exp_q.size() == 0);
      vectors++;
      if (stage !== 3'(k + 1)) begin
        miscompares++;
        $display("FAIL instr op=%h stage: got %0d expected %0d", op, stage, k + 1);
      end
      vectors++;
      if (ctrl_word !== w) begin
        miscompares++;
        $display("FAIL instr op=%h T%0d ctrl_word: got %h expected %h", op, k + 1, ctrl_word, w);
      end
      vectors++;
      if (instr_done !== last) begin
        miscompares++;
        $display("FAIL instr op=%h T%0d instr_done: got %b expected %b", op, k + 1, instr_done, last);
      end
      vectors++;
      if (flags !== mflags) begin
        miscompares++;
        $display("FAIL instr op=%h T%0d flags: got %b expected %b", op, k + 1, flags, mflags);
      end
      if (w[14]) mflags = {c, z};
      if (k == 0) run = run_after;
      k++;
      @(negedge clk);
    end
  endtask

  task automatic check_stage(input string name, input logic [2:0] exp_stage);
    vectors++;
    if (stage !== exp_stage) begin
      miscompares++;
      $display("FAIL %s stage: got %0d expected %0d", name, stage, exp_stage);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0; opcode = 4'h0; carry = 1'b0; zero = 1'b0;
    mflags = 2'b00;
    repeat (2) @(negedge clk);
    vectors++;
    if (stage !== 3'd0 || ctrl_word !== 16'h0000 || flags !== 2'b00 ||
        halted !== 1'b0 || instr_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: got stage=%0d cw=%h flags=%b halted=%b done=%b expected 0/0000/00/0/0",
               stage, ctrl_word, flags, halted, instr_done);
    end
  endtask

  task automatic test_lda();
    rst = 1'b0; run = 1'b1; opcode = 4'h0;
    @(negedge clk);
    exec_instr(4'h0, 1'b0, 1'b0, 1'b1);
    check_stage("lda_next", 3'd1);
  endtask

  task automatic test_add_jc();
    exec_instr(4'h1, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (flags !== 2'b10) begin
      miscompares++;
      $display("FAIL add_flags: got %b expected 10", flags);
    end
    exec_instr(4'h4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    exec_instr(4'h1, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    exec_instr(4'h4, 1'b1, 1'b1, 1'b1);
    check_stage("jc_not_taken_next", 3'd1);
  endtask

  task automatic test_sub_jz();
    exec_instr(4'h2, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    vectors++;
    if (flags[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL sub_zflag: got %b expected 1", flags[0]);
    end
    exec_instr(4'h5, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 14));
      exec_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end
    check_stage("random_next", 3'd1);
  endtask

  task automatic test_undefined();
    exec_instr(4'h9, 1'b0, 1'b0, 1'b1);
    check_stage("undef_next", 3'd1);
  endtask

  task automatic test_step();
    // run drops mid-instruction; the instruction still completes
    exec_instr(4'h0, 1'b0, 1'b0, 1'b0);
    check_stage("run0_wait", 3'd0);
    repeat (3) begin
      @(negedge clk);
      check_stage("wait_hold", 3'd0);
    end
    step = 1'b1;
    @(negedge clk);
    exec_instr(4'h6, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_stage("step_held", 3'd0);
      vectors++;
      if (ctrl_word !== 16'h0000 || instr_done !== 1'b0) begin
        miscompares++;
        $display("FAIL step_held outputs: got cw=%h done=%b expected 0000/0", ctrl_word, instr_done);
      end
      @(negedge clk);
    end
    step = 1'b0;
    @(negedge clk);
    check_stage("step_low", 3'd0);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    exec_instr(4'hE, 1'b0, 1'b0, 1'b1);
    check_stage("step_resume", 3'd1);
  endtask

  task automatic test_halt();
    exec_instr(4'hF, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (stage !== 3'd7 || halted !== 1'b1 || ctrl_word !== 16'h0800) begin
        miscompares++;
        $display("FAIL halt: got stage=%0d halted=%b cw=%h expected 7/1/0800", stage, halted, ctrl_word);
      end
      step = ~step;
      run  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; run = 1'b1; step = 1'b0;
    @(negedge clk);
    rst = 1'b0; mflags = 2'b00;
    @(negedge clk);
    exec_instr(4'h1, 1'b1, 1'b1, 1'b1);
    opcode = 4'h1; carry = 1'b0; zero = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check_stage("pre_reset", 3'(k));
      @(negedge clk);
    end
    check_stage("pre_reset_t5", 3'd5);
    vectors++;
    if (flags !== 2'b11) begin
      miscompares++;
      $display("FAIL pre_reset flags: got %b expected 11", flags);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (stage !== 3'd0 || flags !== 2'b00 || halted !== 1'b0 || ctrl_word !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_mid: got stage=%0d flags=%b halted=%b cw=%h expected 0/00/0/0000",
               stage, flags, halted, ctrl_word);
    end
    @(negedge clk);
    rst = 1'b0; mflags = 2'b00;
    @(negedge clk);
    exec_instr(4'h3, 1'b0, 1'b0, 1'b1);
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_lda();
    test_add_jc();
    test_sub_jz();
    test_undefined();
    test_random();
    test_step();
    test_halt();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
